sparse_block_scheduler: RTL and testbench

SPARSE_BLOCK_SCHEDULER -- requirements
Module: sparse_block_scheduler

---
 rtl/sparse_arithmetic_pkg.sv | 19 +
 rtl/nzc.sv | 14 +
 rtl/sparse_block_scheduler.sv | 142 ++++++++++++++
 tb/tb_sparse_block_scheduler.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sparse_arithmetic_pkg.sv
// Shared definitions for the sparse block scheduler.
//   state_t         : scheduler FSM encoding (IDLE waits for a chunk, ISSUE streams beats)
//   beat_cnt_width  : width of a counter able to index every beat of one chunk
package sparse_arithmetic;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  // Worst case beats per chunk is ceil(weight_blocks / active_blocks);
  // a single-beat design still gets a 1-bit counter.
  function automatic int beat_cnt_width(input int weight_blocks, input int active_blocks);
    int max_beats;
    max_beats = (weight_blocks + active_blocks - 1) / active_blocks;
    return (max_beats <= 1) ? 1 : $clog2(max_beats);
  endfunction

endpackage

// File: rtl/nzc.sv
// Nonzero check for one weight block.
//   elems   : COUNT elements of WIDTH bits
//   nonzero : high when any element is nonzero
module nzc #(
  parameter int WIDTH = 16,
  parameter int COUNT = 4
) (
  input  logic [COUNT-1:0][WIDTH-1:0] elems,
  output logic                        nonzero
);

  assign nonzero = |elems;

endmodule

// File: rtl/sparse_block_scheduler.sv
// Sparse block scheduler: accepts one chunk (activations + weights for
// WEIGHT_BLOCKS blocks) and streams only its nonzero weight blocks downstream,
// up to ACTIVE_BLOCKS blocks per beat in ascending block order.
//   clk, rst                      : clock, synchronous active-low reset
//   data_in/_valid/_ready         : activation chunk input
//   weight/_valid/_ready          : weight chunk input (ready mirrors data_in_ready)
//   data_out, weight_out          : selected lanes, unused lanes zero
//   data_out_valid/_ready         : downstream handshake
//   beat_last, vec_last           : last beat of chunk / of vector
//   fsm_state, beat_idx           : debug view of FSM state and beat index
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. valid never depends on ready; while valid is high and ready low all
// payload outputs hold.
module sparse_block_scheduler
  import sparse_arithmetic::*;
#(
  parameter  int BLOCK_SIZE    = 4,
  parameter  int WEIGHT_BLOCKS = 3,
  parameter  int ACTIVE_BLOCKS = 1,
  parameter  int IN_DEPTH      = 3,
  parameter  int IN_WIDTH      = 32,
  parameter  int WEIGHT_WIDTH  = 16,
  localparam int N_IN          = BLOCK_SIZE * WEIGHT_BLOCKS,
  localparam int N_OUT         = BLOCK_SIZE * ACTIVE_BLOCKS,
  localparam int BEAT_W        = beat_cnt_width(WEIGHT_BLOCKS, ACTIVE_BLOCKS)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_IN-1:0][IN_WIDTH-1:0]       data_in,
  input  logic                                data_in_valid,
  output logic                                data_in_ready,
  input  logic [N_IN-1:0][WEIGHT_WIDTH-1:0]   weight,
  input  logic                                weight_valid,
  output logic                                weight_ready,
  output logic [N_OUT-1:0][IN_WIDTH-1:0]      data_out,
  output logic [N_OUT-1:0][WEIGHT_WIDTH-1:0]  weight_out,
  output logic                                data_out_valid,
  input  logic                                data_out_ready,
  output logic                                beat_last,
  output logic                                vec_last,
  output state_t                              fsm_state,
  output logic [BEAT_W-1:0]                   beat_idx
);

  localparam int CNT_W = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;

  state_t                             state_q, state_d;
  logic [N_IN-1:0][IN_WIDTH-1:0]      data_q;
  logic [N_IN-1:0][WEIGHT_WIDTH-1:0]  weight_q;
  logic [WEIGHT_BLOCKS-1:0]           nz_mask;
  logic [WEIGHT_BLOCKS-1:0]           mask_q;   // blocks still to be issued
  logic [WEIGHT_BLOCKS-1:0]           issued;   // blocks presented this beat
  logic [BEAT_W-1:0]                  beat_q;
  logic [CNT_W-1:0]                   chunk_q;
  logic                               ready;
  logic                               accept;
  logic                               out_fire;

  for (genvar j = 0; j < WEIGHT_BLOCKS; j++) begin : g_nzc
    nzc #(
      .WIDTH (WEIGHT_WIDTH),
      .COUNT (BLOCK_SIZE)
    ) u_nzc (
      .elems   (weight[j*BLOCK_SIZE +: BLOCK_SIZE]),
      .nonzero (nz_mask[j])
    );
  end

  assign data_out_valid = (state_q == ISSUE);
  assign out_fire       = data_out_valid && data_out_ready;
  // An all-zero chunk has an empty mask and is therefore last on its only beat.
  assign beat_last      = data_out_valid && ((mask_q & ~issued) == '0);
  assign vec_last       = beat_last && (chunk_q == CNT_W'(IN_DEPTH - 1));
  // Ready also opens on the final handshake so the next chunk follows with no bubble.
  assign ready          = rst && ((state_q == IDLE) || (out_fire && beat_last));
  assign data_in_ready  = ready;
  assign weight_ready   = ready;
  assign accept         = ready && data_in_valid && weight_valid;
  assign fsm_state      = state_q;
  assign beat_idx       = beat_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   if (out_fire && beat_last && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Priority encoder over the remaining mask: the k-th set bit (lowest index
  // first) lands on lane k; lanes with no block stay zero.
  always_comb begin
    int rank;
    rank       = 0;
    issued     = '0;
    data_out   = '0;
    weight_out = '0;
    if (state_q == ISSUE) begin
      for (int j = 0; j < WEIGHT_BLOCKS; j++) begin
        if (mask_q[j]) begin
          for (int k = 0; k < ACTIVE_BLOCKS; k++) begin
            if (rank == k) begin
              data_out[k*BLOCK_SIZE +: BLOCK_SIZE]   = data_q[j*BLOCK_SIZE +: BLOCK_SIZE];
              weight_out[k*BLOCK_SIZE +: BLOCK_SIZE] = weight_q[j*BLOCK_SIZE +: BLOCK_SIZE];
              issued[j] = 1'b1;
            end
          end
          rank = rank + 1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      data_q   <= '0;
      weight_q <= '0;
      mask_q   <= '0;
      beat_q   <= '0;
      chunk_q  <= '0;
    end else begin
      state_q <= state_d;
      // A new chunk overrides the bookkeeping of the one just finishing.
      if (accept) begin
        data_q   <= data_in;
        weight_q <= weight;
        mask_q   <= nz_mask;
        beat_q   <= '0;
      end else if (out_fire) begin
        mask_q <= mask_q & ~issued;
        beat_q <= beat_last ? '0 : beat_q + 1'b1;
      end
      if (out_fire && beat_last) begin
        chunk_q <= (chunk_q == CNT_W'(IN_DEPTH - 1)) ? '0 : chunk_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sparse_block_scheduler.sv
// Self-checking bench for sparse_block_scheduler with default parameters.
module tb_sparse_block_scheduler;
  import sparse_arithmetic::*;

  localparam int BS    = 4;
  localparam int WB    = 3;
  localparam int AB    = 1;
  localparam int DEPTH = 3;
  localparam int IW    = 32;
  localparam int WW    = 16;
  localparam int EW    = 2 + BS*AB*WW + BS*AB*IW;

  logic                        clk;
  logic                        rst;
  logic [BS*WB-1:0][IW-1:0]    data_in;
  logic                        data_in_valid;
  logic                        data_in_ready;
  logic [BS*WB-1:0][WW-1:0]    weight;
  logic                        weight_valid;
  logic                        weight_ready;
  logic [BS*AB-1:0][IW-1:0]    data_out;
  logic [BS*AB-1:0][WW-1:0]    weight_out;
  logic                        data_out_valid;
  logic                        data_out_ready;
  logic                        beat_last;
  logic                        vec_last;
  state_t                      fsm_state;
  logic [1:0]                  beat_idx;

  sparse_block_scheduler dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .weight         (weight),
    .weight_valid   (weight_valid),
    .weight_ready   (weight_ready),
    .data_out       (data_out),
    .weight_out     (weight_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .beat_last      (beat_last),
    .vec_last       (vec_last),
    .fsm_state      (fsm_state),
    .beat_idx       (beat_idx)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- vector table ----------------
  // Weight element e of block j = we[j][e] ? wf[j] : 0.
  // Data element e of block j   = df[j] (+ e when ramp).
  // Expected beat b carries block with fill ewf[b]/ewe[b]/edf[b]; ewe==0 means an all-zero lane.
  typedef struct {
    logic [WW-1:0] wf  [WB];
    logic [BS-1:0] we  [WB];
    logic [IW-1:0] df  [WB];
    logic          ramp;
    int            nb;
    logic [WW-1:0] ewf [WB];
    logic [BS-1:0] ewe [WB];
    logic [IW-1:0] edf [WB];
  } vec_t;

  vec_t vt [6];

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q [$];
  int            push_chunk;
  int            ready_mode;   // 0: always ready, 1: random stalls, 2: driven by hand
  int            n_checks;
  int            n_fail;
  logic [EW-1:0] mon_cur;
  logic [EW-1:0] mon_exp;
  logic [EW-1:0] stall_exp;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] make_exp(input int i, input int b, input logic vl);
    logic [BS-1:0][WW-1:0] w;
    logic [BS-1:0][IW-1:0] d;
    for (int e = 0; e < BS; e++) begin
      w[e] = vt[i].ewe[b][e] ? vt[i].ewf[b] : '0;
      if (vt[i].ewe[b] == '0)
        d[e] = '0;
      else
        d[e] = vt[i].ramp ? vt[i].edf[b] + IW'(e) : vt[i].edf[b];
    end
    return {vl, (b == vt[i].nb - 1), w, d};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_inputs(input int i);
    for (int j = 0; j < WB; j++) begin
      for (int e = 0; e < BS; e++) begin
        weight[j*BS+e]  = vt[i].we[j][e] ? vt[i].wf[j] : '0;
        data_in[j*BS+e] = vt[i].ramp ? vt[i].df[j] + IW'(e) : vt[i].df[j];
      end
    end
    data_in_valid = 1'b1;
    weight_valid  = 1'b1;
  endtask

  task automatic push_expected(input int i);
    for (int b = 0; b < vt[i].nb; b++)
      exp_q.push_back(make_exp(i, b, (b == vt[i].nb - 1) && (push_chunk == DEPTH - 1)));
    push_chunk = (push_chunk == DEPTH - 1) ? 0 : push_chunk + 1;
  endtask

  // Called at posedge+#1; returns at posedge+#1 right after the accepting edge.
  task automatic send_chunk(input int i);
    int n;
    push_expected(i);
    drive_inputs(i);
    n = 0;
    @(negedge clk);
    while (!data_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", data_in_ready, 1'b1);
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
    weight_valid  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || data_out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_queue", exp_q.size(), 0);
    check("drain_idle", data_out_valid, 1'b0);
  endtask

  // ---------------- downstream ready driver ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0)      data_out_ready = 1'b1;
      else if (ready_mode == 1) data_out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst && data_out_valid && data_out_ready) begin
      mon_cur = {vec_last, beat_last, weight_out, data_out};
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got %0h expected no beat (t=%0t)", mon_cur, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("beat", mon_cur, mon_exp);
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    vt[0].wf = '{16'h0, 16'h5, 16'h0};  vt[0].we = '{4'hF, 4'hF, 4'hF};
    vt[0].df = '{32'h7, 32'h7, 32'h7};  vt[0].ramp = 1'b0;  vt[0].nb = 1;
    vt[0].ewf = '{16'h5, 16'h0, 16'h0}; vt[0].ewe = '{4'hF, 4'h0, 4'h0};
    vt[0].edf = '{32'h7, 32'h0, 32'h0};

    vt[1].wf = '{16'h1, 16'h2, 16'h3};  vt[1].we = '{4'hF, 4'hF, 4'hF};
    vt[1].df = '{32'h10, 32'h20, 32'h30}; vt[1].ramp = 1'b1; vt[1].nb = 3;
    vt[1].ewf = '{16'h1, 16'h2, 16'h3}; vt[1].ewe = '{4'hF, 4'hF, 4'hF};
    vt[1].edf = '{32'h10, 32'h20, 32'h30};

    vt[2].wf = '{16'h0, 16'h0, 16'h0};  vt[2].we = '{4'hF, 4'hF, 4'hF};
    vt[2].df = '{32'hAA, 32'hBB, 32'hCC}; vt[2].ramp = 1'b1; vt[2].nb = 1;
    vt[2].ewf = '{16'h0, 16'h0, 16'h0}; vt[2].ewe = '{4'h0, 4'h0, 4'h0};
    vt[2].edf = '{32'h0, 32'h0, 32'h0};

    vt[3].wf = '{16'h1234, 16'h0, 16'hBEEF}; vt[3].we = '{4'h8, 4'hF, 4'h1};
    vt[3].df = '{32'h1, 32'h2, 32'h3};  vt[3].ramp = 1'b1;  vt[3].nb = 2;
    vt[3].ewf = '{16'h1234, 16'hBEEF, 16'h0}; vt[3].ewe = '{4'h8, 4'h1, 4'h0};
    vt[3].edf = '{32'h1, 32'h3, 32'h0};

    vt[4].wf = '{16'h0, 16'h0, 16'h9};  vt[4].we = '{4'hF, 4'hF, 4'hF};
    vt[4].df = '{32'h4, 32'h5, 32'h6};  vt[4].ramp = 1'b1;  vt[4].nb = 1;
    vt[4].ewf = '{16'h9, 16'h0, 16'h0}; vt[4].ewe = '{4'hF, 4'h0, 4'h0};
    vt[4].edf = '{32'h6, 32'h0, 32'h0};

    vt[5].wf = '{16'h7, 16'h8, 16'h0};  vt[5].we = '{4'hF, 4'hF, 4'hF};
    vt[5].df = '{32'h11, 32'h22, 32'h33}; vt[5].ramp = 1'b1; vt[5].nb = 2;
    vt[5].ewf = '{16'h7, 16'h8, 16'h0}; vt[5].ewe = '{4'hF, 4'hF, 4'h0};
    vt[5].edf = '{32'h11, 32'h22, 32'h0};

    n_checks       = 0;
    n_fail         = 0;
    push_chunk     = 0;
    ready_mode     = 0;
    rst            = 1'b0;
    data_in        = '0;
    weight         = '0;
    data_in_valid  = 1'b0;
    weight_valid   = 1'b0;
    data_out_ready = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_data_in_ready", data_in_ready, 1'b0);
    check("rst_weight_ready", weight_ready, 1'b0);
    check("rst_valid", data_out_valid, 1'b0);
    check("rst_beat_last", beat_last, 1'b0);
    check("rst_vec_last", vec_last, 1'b0);
    check("rst_data_out", data_out, '0);
    check("rst_weight_out", weight_out, '0);
    check("rst_state", fsm_state, IDLE);
    check("rst_beat_idx", beat_idx, 2'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_rst", data_in_ready, 1'b1);
    check("wready_after_rst", weight_ready, 1'b1);
    @(posedge clk);
    #1;

    // Single nonzero block, repeated: vec_last on the third chunk, wrap on the fourth.
    for (int c = 0; c < 4; c++) send_chunk(0);
    drain();

    // Table pass with downstream always ready, then with random stalls.
    for (int i = 0; i < 6; i++) send_chunk(i);
    drain();
    ready_mode = 1;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 6; i++) send_chunk(i);
    drain();
    ready_mode = 0;
    data_out_ready = 1'b1;

    // Back-to-back: dense chunk followed by a chunk held valid throughout.
    send_chunk(1);
    drive_inputs(0);
    push_expected(0);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      check("b2b_ready", data_in_ready, (b == 2));
      check("b2b_beat_last", beat_last, (b == 2));
    end
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
    weight_valid  = 1'b0;
    @(negedge clk);
    check("b2b_zero_bubble", data_out_valid, 1'b1);
    @(posedge clk);
    #1;
    drain();

    // All-zero chunk: one empty beat, then ready again.
    send_chunk(2);
    @(negedge clk);
    check("zero_beat_last", beat_last, 1'b1);
    check("zero_weight_out", weight_out, '0);
    check("zero_data_out", data_out, '0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("zero_ready_again", data_in_ready, 1'b1);
    check("zero_valid_low", data_out_valid, 1'b0);
    @(posedge clk);
    #1;

    // Stall on first beat of a 3'b101 chunk.
    ready_mode     = 2;
    data_out_ready = 1'b0;
    send_chunk(3);
    stall_exp = make_exp(3, 0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("stall_valid", data_out_valid, 1'b1);
      check("stall_weight", weight_out, stall_exp[EW-3 -: BS*AB*WW]);
      check("stall_data", data_out, stall_exp[BS*AB*IW-1:0]);
      check("stall_beat_last", beat_last, 1'b0);
      @(posedge clk);
      #1;
    end
    ready_mode     = 0;
    data_out_ready = 1'b1;
    drain();

    // Reset during the second beat of a dense chunk.
    send_chunk(1);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready_low", data_in_ready, 1'b0);
    @(posedge clk);
    #1;
    exp_q.delete();
    push_chunk = 0;
    @(negedge clk);
    check("midrst_valid", data_out_valid, 1'b0);
    check("midrst_ready", data_in_ready, 1'b0);
    check("midrst_state", fsm_state, IDLE);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) send_chunk(0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit in case a handshake never completes.
  initial begin
    #200000;
    $display("FAIL timeout: got no end of test expected completion");
    $fatal(1, "time limit reached");
  end

endmodule
